shot_manager: RTL and testbench
===============================

Name: shot_manager

Overview:
Owns the shot entity table that feeds the collision controller's `shots` input. It spawns shots from the ship's position and heading on a fire request and advances every active shot once per frame tick. It clears slots on `delete_shot`/`shot_address` requests coming back from the collision controller. It sits between player input and ship state upstream, and collision and rendering downstream.

Parameters:
MAX_SHOTS, 3, number of shot slots (1..1023)
ENTITY_SIZE, 34, entity word width
SHOT_SPEED, 4, pixels moved per tick per non-zero axis component (10-bit unsigned)
COOLDOWN, 8, cycles after a spawn during which fire is ignored
SHOT_LIFETIME, 60, ticks before auto-expiry (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fire  in  1  fire request, sampled each cycle
tick  in  1  one-cycle frame-advance strobe
ship  in  ENTITY_SIZE  ship entity word
delete_shot  in  1  delete request from collision controller
shot_address  in  10  slot index to delete
shots  out  MAX_SHOTS x ENTITY_SIZE  shot table, registered
fire_ack  out  1  one-cycle pulse: shot spawned
busy  out  1  high while state MOVE
shot_count  out  10  number of active slots

Behaviour:
- Entity word layout: [33] active, [32:26] zero, [25:16] y, [15:6] x, [5:3] zero, [2:0] dir.
  - dir encoding: 0=N(y-), 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW.
- Reset, synchronous: all shots words = 0; fire_ack = 0; busy = 0; shot_count = 0; cooldown counter = 0; fire_pending = 0; state = IDLE.
- States:
  - IDLE:
    - tick -> MOVE, idx=0.
    - Otherwise (fire or fire_pending) and cooldown==0 -> SPAWN.
    - tick takes priority over fire; a fire seen in the same cycle sets fire_pending.
  - SPAWN, one cycle:
    - Select the lowest-index slot with active=0.
    - Write {1, 7'b0, ship[25:16], ship[15:6], 3'b0, ship[2:0]}.
    - fire_ack = 1 next cycle; cooldown = COOLDOWN; clear fire_pending; -> IDLE.
    - No free slot: nothing written, no fire_ack, cooldown not loaded, fire_pending cleared -> IDLE.
  - MOVE, MAX_SHOTS cycles, one slot per cycle (slot idx updated at cycle idx):
    - Active slot: x/y += or -= SHOT_SPEED per dir, modulo 1024.
    - Underflow therefore yields values > 320, which the collision controller deletes.
    - Inactive slots are unchanged.
    - After the last idx -> IDLE.
    - fire during MOVE (when cooldown==0) sets fire_pending.
    - tick during MOVE is ignored; at most one move per tick.
- Cooldown counter:
  - Decrements each cycle while non-zero.
  - fire while cooldown != 0 and state IDLE is dropped, not pended.
- Delete:
  - Processed in every state, same cycle: shot_address < MAX_SHOTS -> that slot's word = 0 on the next edge.
  - shot_address >= MAX_SHOTS is ignored.
  - Delete on the slot being moved in that cycle: delete wins.
  - Delete on the slot being spawned in that cycle: spawn wins, because the slot was inactive.
- shot_count: registered popcount of active bits; reflects the table one cycle after the change.
- Latency:
  - fire in IDLE with cooldown 0 -> slot written at edge+2 (IDLE samples, SPAWN writes); fire_ack high the cycle after the write.
  - tick -> all slots updated MAX_SHOTS+1 edges later.
- Reset mid-MOVE or mid-SPAWN: table fully cleared, no partial update retained.

Optional Feature:
SHOT_LIFETIME_EN
- Defined:
  - Each slot has a lifetime counter, loaded with SHOT_LIFETIME at spawn and decremented when the slot is processed in MOVE.
  - When the counter reaches 0, the slot is cleared in that same MOVE cycle instead of moved.
  - Delete clears the counter.
- Undefined:
  - No counters.
  - Shots persist until deleted by the collision controller.

Test Plan:
1. Reset, ship x=100 y=50 dir=2, pulse fire -> slot0 = active, x=100, y=50, dir=2 two edges later; fire_ack pulses once; shot_count=1.
2. From 1, pulse tick -> busy high 3 cycles; slot0 x=104 y=50; slots1-2 remain 0.
3. Shot at x=2 dir=6, tick -> x=1022 (wrapped); assert delete_shot, shot_address=0 -> slot0=0, shot_count=0.
4. Fire every cycle for 40 cycles, COOLDOWN=8 -> exactly 3 spawns into slots 0,1,2, spaced >= 9 cycles apart; later fires produce no fire_ack while the table is full.
5. Fire pulsed during MOVE -> fire_pending set; spawn occurs immediately after MOVE ends. In the same MOVE cycle as slot1 is processed, delete slot1 -> slot1=0 (not moved). shot_address=5 -> table unchanged.
6. With SHOT_LIFETIME_EN and SHOT_LIFETIME=2, spawn, then issue 2 ticks -> moved once, cleared on the second tick. Without the macro -> moved twice, still active.

Source files
------------

// File: rtl/shot_manager.sv
// shot_manager: owns the shot entity table that feeds the collision controller.
// Spawns a shot from the ship position/heading on fire, advances every active
// shot once per frame tick (one slot per cycle), and clears slots on delete.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   fire          fire request, sampled each cycle
//   tick          one-cycle frame-advance strobe
//   ship          ship entity word
//   delete_shot   delete request from collision controller
//   shot_address  slot index to delete (ignored when >= MAX_SHOTS)
//   shots         registered shot table, slot i at shots[i]
//   fire_ack      one-cycle pulse: shot spawned
//   busy          high while the table is being advanced
//   shot_count    number of active slots (lags the table by one cycle)
//
// Optional feature macro: SHOT_LIFETIME_EN (per-slot lifetime auto-expiry).
module shot_manager #(
  parameter int unsigned MAX_SHOTS     = 3,
  parameter int unsigned ENTITY_SIZE   = 34,
  parameter int unsigned SHOT_SPEED    = 4,
  parameter int unsigned COOLDOWN      = 8,
  parameter int unsigned SHOT_LIFETIME = 60
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    fire,
  input  logic                                    tick,
  input  logic [ENTITY_SIZE-1:0]                  ship,
  input  logic                                    delete_shot,
  input  logic [9:0]                              shot_address,
  output logic [MAX_SHOTS-1:0][ENTITY_SIZE-1:0]   shots,
  output logic                                    fire_ack,
  output logic                                    busy,
  output logic [9:0]                              shot_count
);

  localparam int unsigned ACT  = ENTITY_SIZE - 1;
  localparam int unsigned CD_W = 16;
  localparam logic [9:0]  SPD  = 10'(SHOT_SPEED);

  typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_MOVE} state_t;

  state_t                               r_state, w_next;
  logic [9:0]                           r_idx, w_idx_next;
  logic                                 r_pending, w_pending_next;
  logic [CD_W-1:0]                      r_cd;
  logic [MAX_SHOTS-1:0][ENTITY_SIZE-1:0] r_shots;
  logic                                 r_fire_ack, r_busy;
  logic [9:0]                           r_count, w_count;
  logic                                 w_found;
  logic [9:0]                           w_sel;
  logic [ENTITY_SIZE-1:0]               w_spawn;
  logic                                 w_spawn_ok;

`ifdef SHOT_LIFETIME_EN
  localparam int unsigned LW = 16;
  logic [LW-1:0] r_life [MAX_SHOTS];
  logic          w_unused_ship;
  assign w_unused_ship = ^{ship[ENTITY_SIZE-1:26], ship[5:3]};
`else
  logic          w_unused_ship;
  assign w_unused_ship = ^{ship[ENTITY_SIZE-1:26], ship[5:3], 32'(SHOT_LIFETIME)};
`endif

  assign shots      = r_shots;
  assign fire_ack   = r_fire_ack;
  assign busy       = r_busy;
  assign shot_count = r_count;

  // Spawned word keeps only position and heading from the ship.
  assign w_spawn    = ENTITY_SIZE'({1'b1, 7'b0, ship[25:16], ship[15:6], 3'b0, ship[2:0]});
  assign w_spawn_ok = (r_state == S_SPAWN) && w_found;

  // One step of a shot along its heading; 10-bit arithmetic wraps modulo 1024.
  function automatic logic [ENTITY_SIZE-1:0] f_move(input logic [ENTITY_SIZE-1:0] e);
    logic [9:0] x, y;
    x = e[15:6];
    y = e[25:16];
    case (e[2:0])
      3'd0: y = y - SPD;
      3'd1: begin x = x + SPD; y = y - SPD; end
      3'd2: x = x + SPD;
      3'd3: begin x = x + SPD; y = y + SPD; end
      3'd4: y = y + SPD;
      3'd5: begin x = x - SPD; y = y + SPD; end
      3'd6: x = x - SPD;
      default: begin x = x - SPD; y = y - SPD; end
    endcase
    f_move        = e;
    f_move[15:6]  = x;
    f_move[25:16] = y;
  endfunction

  // Lowest-index free slot.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = int'(MAX_SHOTS) - 1; i >= 0; i--) begin
      if (!r_shots[i][ACT]) begin
        w_found = 1'b1;
        w_sel   = 10'(i);
      end
    end
  end

  // Active-slot popcount.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < int'(MAX_SHOTS); i++) begin
      w_count = w_count + 10'(r_shots[i][ACT]);
    end
  end

  // State register and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_cd       <= '0;
      r_fire_ack <= 1'b0;
      r_busy     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_next;
      r_idx      <= w_idx_next;
      r_pending  <= w_pending_next;
      r_fire_ack <= w_spawn_ok;
      r_busy     <= (w_next == S_MOVE);
      r_count    <= w_count;
      if (w_spawn_ok)       r_cd <= CD_W'(COOLDOWN);
      else if (r_cd != '0)  r_cd <= r_cd - CD_W'(1);
    end
  end

  // Next-state logic; tick wins over fire in IDLE, a coincident fire is pended.
  always_comb begin
    w_next         = r_state;
    w_idx_next     = r_idx;
    w_pending_next = r_pending;
    case (r_state)
      S_IDLE: begin
        if (tick) begin
          w_next     = S_MOVE;
          w_idx_next = '0;
          if (fire) w_pending_next = 1'b1;
        end else if ((fire || r_pending) && (r_cd == '0)) begin
          w_next = S_SPAWN;
        end
      end
      S_SPAWN: begin
        w_pending_next = 1'b0;
        w_next         = S_IDLE;
      end
      S_MOVE: begin
        if (fire && (r_cd == '0)) w_pending_next = 1'b1;
        if (r_idx == 10'(MAX_SHOTS - 1)) w_next = S_IDLE;
        else                             w_idx_next = r_idx + 10'd1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Shot table: move, then delete overrides move, then spawn overrides delete.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shots <= '0;
`ifdef SHOT_LIFETIME_EN
      for (int i = 0; i < int'(MAX_SHOTS); i++) r_life[i] <= '0;
`endif
    end else begin
      for (int i = 0; i < int'(MAX_SHOTS); i++) begin
        if ((r_state == S_MOVE) && (r_idx == 10'(i)) && r_shots[i][ACT]) begin
`ifdef SHOT_LIFETIME_EN
          // Expire instead of moving when this is the last lifetime step.
          if (r_life[i] <= LW'(1)) begin
            r_shots[i] <= '0;
            r_life[i]  <= '0;
          end else begin
            r_shots[i] <= f_move(r_shots[i]);
            r_life[i]  <= r_life[i] - LW'(1);
          end
`else
          r_shots[i] <= f_move(r_shots[i]);
`endif
        end
        if (delete_shot && (shot_address == 10'(i))) begin
          r_shots[i] <= '0;
`ifdef SHOT_LIFETIME_EN
          r_life[i]  <= '0;
`endif
        end
        if (w_spawn_ok && (w_sel == 10'(i))) begin
          r_shots[i] <= w_spawn;
`ifdef SHOT_LIFETIME_EN
          r_life[i]  <= LW'(SHOT_LIFETIME);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_shot_manager.sv
// Scoreboard bench for shot_manager: stimulus pushes expected spawn / move
// results; a monitor pops them on fire_ack or on the end of busy.
module tb_shot_manager;

  logic              clk;
  logic              reset;
  logic              fire;
  logic              tick;
  logic [33:0]       ship;
  logic              delete_shot;
  logic [9:0]        shot_address;
  logic [2:0][33:0]  shots;
  logic              fire_ack;
  logic              busy;
  logic [9:0]        shot_count;

  shot_manager #(
    .MAX_SHOTS(3), .ENTITY_SIZE(34), .SHOT_SPEED(4), .COOLDOWN(8), .SHOT_LIFETIME(2)
  ) dut (
    .clk(clk), .reset(reset), .fire(fire), .tick(tick), .ship(ship),
    .delete_shot(delete_shot), .shot_address(shot_address), .shots(shots),
    .fire_ack(fire_ack), .busy(busy), .shot_count(shot_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               kind;   // 0 = spawn, 1 = move finished
    int               slot;
    logic [33:0]      word;
    logic [9:0]       cnt;
    logic [2:0][33:0] tab;
    int               blen;
  } exp_t;

  exp_t q[$];
  int   ack_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_acks   = 0;
  int   exp_acks = 0;
  int   cyc      = 0;
  int   busy_len = 0;
  logic prev_busy = 1'b0;
  logic cnt_pend  = 1'b0;
  logic [9:0] cnt_exp = '0;

  always @(posedge clk) cyc++;

  function automatic logic [33:0] mk(input int x, input int y, input int d);
    mk = {1'b1, 7'b0, 10'(y), 10'(x), 3'b0, 3'(d)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_spawn(input int slot, input logic [33:0] w, input logic [9:0] c);
    exp_t e;
    e.kind = 0; e.slot = slot; e.word = w; e.cnt = c; e.tab = '0; e.blen = 0;
    q.push_back(e);
    exp_acks++;
  endtask

  task automatic push_move(input logic [2:0][33:0] t);
    exp_t e;
    e.kind = 1; e.slot = 0; e.word = '0; e.cnt = '0; e.tab = t; e.blen = 3;
    q.push_back(e);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n && q.size() != 0; k++) step();
    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d expected outputs still pending", q.size());
      q.delete();
    end
    repeat (2) step();
  endtask

  task automatic del(input logic [9:0] a);
    delete_shot = 1'b1; shot_address = a;
    step();
    delete_shot = 1'b0;
  endtask

  // Monitor: compares DUT outputs against the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_busy = 1'b0;
      busy_len  = 0;
      cnt_pend  = 1'b0;
    end else begin
      if (cnt_pend) begin
        chk("count_after_spawn", 128'(shot_count), 128'(cnt_exp));
        cnt_pend = 1'b0;
      end
      if (busy) busy_len++;
      if (fire_ack) begin
        n_acks++;
        ack_cyc.push_back(cyc);
        if (q.size() == 0 || q[0].kind != 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_ack: fire_ack=1 at cycle %0d with no spawn expected", cyc);
        end else begin
          e = q.pop_front();
          chk("spawn_word", 128'(shots[e.slot]), 128'(e.word));
          cnt_exp  = e.cnt;
          cnt_pend = 1'b1;
        end
      end
      if (prev_busy && !busy) begin
        if (q.size() == 0 || q[0].kind != 1) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_move_end: busy fell at cycle %0d with no move expected", cyc);
        end else begin
          e = q.pop_front();
          chk("move_table", 128'(shots), 128'(e.tab));
          chk("busy_len", 128'(busy_len), 128'(e.blen));
        end
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0][33:0] t;
    fire = 0; tick = 0; delete_shot = 0; shot_address = '0; ship = '0; reset = 1;
    repeat (3) step();
    chk("rst_shots", 128'(shots), 128'(0));
    chk("rst_count", 128'(shot_count), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ack", 128'(fire_ack), 128'(0));
    reset = 0;
    step();

    // 1: spawn from ship with junk in the zero fields
    ship = {1'b1, 7'h55, 10'd50, 10'd100, 3'b101, 3'd2};
    push_spawn(0, mk(100, 50, 2), 10'd1);
    fire = 1; step(); fire = 0; step();
    chk("t1_write_latency", 128'(shots[0]), 128'(mk(100, 50, 2)));
    chk("t1_ack_high", 128'(fire_ack), 128'(1));
    step();
    chk("t1_ack_pulse", 128'(fire_ack), 128'(0));
    drain(20);

    // 2: tick moves slot0 east
    push_move({34'b0, 34'b0, mk(104, 50, 2)});
    tick = 1; step(); tick = 0;
    drain(20);
    chk("t2_count", 128'(shot_count), 128'(1));
    repeat (10) step();

    // 3: west wrap past zero, then delete
    del(10'd0);
    chk("t3_del_clear", 128'(shots), 128'(0));
    step();
    chk("t3_del_count", 128'(shot_count), 128'(0));
    repeat (10) step();
    ship = mk(2, 60, 6);
    push_spawn(0, mk(2, 60, 6), 10'd1);
    fire = 1; step(); fire = 0;
    drain(20);
    push_move({34'b0, 34'b0, mk(1022, 60, 6)});
    tick = 1; step(); tick = 0;
    drain(20);
    del(10'd0);
    chk("t3_del2_clear", 128'(shots), 128'(0));
    step();
    chk("t3_del2_count", 128'(shot_count), 128'(0));
    repeat (10) step();

    // 4: continuous fire fills the table under cooldown
    ack_cyc.delete();
    ship = mk(10, 20, 4);
    push_spawn(0, mk(10, 20, 4), 10'd1);
    push_spawn(1, mk(10, 20, 4), 10'd2);
    push_spawn(2, mk(10, 20, 4), 10'd3);
    fire = 1;
    repeat (40) step();
    fire = 0;
    drain(20);
    chk("t4_ack_total", 128'(ack_cyc.size()), 128'(3));
    if (ack_cyc.size() == 3) begin
      chk("t4_spacing01", 128'(ack_cyc[1] - ack_cyc[0] >= 9), 128'(1));
      chk("t4_spacing12", 128'(ack_cyc[2] - ack_cyc[1] >= 9), 128'(1));
    end
    chk("t4_count", 128'(shot_count), 128'(3));

    // 5: pended fire during MOVE, delete wins over move, out-of-range delete ignored
    del(10'd2);
    chk("t5_del2", 128'(shots[2]), 128'(0));
    repeat (10) step();
    ship = mk(200, 100, 1);
    push_move({34'b0, 34'b0, mk(10, 24, 4)});
    push_spawn(1, mk(200, 100, 1), 10'd2);
    tick = 1; step(); tick = 0;
    fire = 1; step(); fire = 0;
    del(10'd1);
    drain(30);
    t = {34'b0, mk(200, 100, 1), mk(10, 24, 4)};
    del(10'd5);
    chk("t5_addr5_ignored", 128'(shots), 128'(t));
    del(10'd3);
    chk("t5_addr3_ignored", 128'(shots), 128'(t));
    repeat (10) step();

    // 6: lifetime behaviour over two ticks
    del(10'd0);
    del(10'd1);
    repeat (10) step();
    chk("t6_empty", 128'(shots), 128'(0));
    ship = mk(500, 500, 3);
    push_spawn(0, mk(500, 500, 3), 10'd1);
    fire = 1; step(); fire = 0;
    drain(20);
    push_move({34'b0, 34'b0, mk(504, 504, 3)});
    tick = 1; step(); tick = 0;
    drain(20);
`ifdef SHOT_LIFETIME_EN
    push_move({34'b0, 34'b0, 34'b0});
`else
    push_move({34'b0, 34'b0, mk(508, 508, 3)});
`endif
    tick = 1; step(); tick = 0;
    drain(20);

    // 7: reset in the middle of MOVE
    tick = 1; step(); tick = 0;
    step();
    reset = 1;
    step();
    chk("t7_rst_shots", 128'(shots), 128'(0));
    chk("t7_rst_busy", 128'(busy), 128'(0));
    chk("t7_rst_count", 128'(shot_count), 128'(0));
    reset = 0;
    repeat (5) step();

    chk("sb_empty", 128'(q.size()), 128'(0));
    chk("ack_total", 128'(n_acks), 128'(exp_acks));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
